// File: rtl/pwm_audio_out_pkg.sv
// Shared definitions for the stereo PWM audio output stage: default widths,
// FIFO depth, FIFO operation encoding and the mid-scale (silence) duty helper.
package pwm_audio_out_pkg;

    localparam int PWM_W_DEF    = 8;
    localparam int SAMPLE_W_DEF = 16;
    localparam int FIFO_DEPTH   = 2;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } fifo_op_e;

    // Half of the PWM period: the duty that reproduces a zero-valued sample.
    function automatic int unsigned mid_scale(input int unsigned pwm_w);
        return 32'd1 << (pwm_w - 1);
    endfunction

endpackage

// File: rtl/pwm_audio_chan.sv
// One PWM audio channel: offset-binary conversion of a signed sample, duty
// register loaded at period boundaries, and the registered PWM comparator.
// Build option PWM_AUDIO_NOISE_SHAPE_EN adds first-order error feedback: the
// bits dropped when forming the duty are carried into the next sample.
module pwm_audio_chan
    import pwm_audio_out_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int PWM_W    = PWM_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                load,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [PWM_W-1:0]    cnt,
    output logic                pwm
);

    localparam int ERR_W = SAMPLE_W - PWM_W;
    localparam logic [PWM_W-1:0] DUTY_RST = PWM_W'(mid_scale(PWM_W));

    logic [SAMPLE_W-1:0] u;
    logic [PWM_W-1:0]    duty;
    logic [PWM_W-1:0]    duty_nxt;

    // Inverting the sign bit shifts two's complement onto 0 .. 2^SAMPLE_W-1.
    assign u = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};

`ifdef PWM_AUDIO_NOISE_SHAPE_EN
    logic [ERR_W-1:0]  err;
    logic [ERR_W-1:0]  err_nxt;
    logic [SAMPLE_W:0] sum;
    logic [SAMPLE_W-1:0] sat;

    // Add the carried error and clamp, so full-scale input never wraps to zero duty.
    always_comb begin
        sum      = {1'b0, u} + (SAMPLE_W+1)'(err);
        sat      = sum[SAMPLE_W] ? '1 : sum[SAMPLE_W-1:0];
        duty_nxt = sat[SAMPLE_W-1 -: PWM_W];
        err_nxt  = sat[ERR_W-1:0];
    end

    // Error only advances when a new sample is consumed; underruns leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else if (load) begin
            err <= err_nxt;
        end
    end
`else
    logic unused_lsbs;

    // Plain truncation: the low sample bits are simply dropped.
    assign duty_nxt    = u[SAMPLE_W-1 -: PWM_W];
    assign unused_lsbs = ^u[ERR_W-1:0];
`endif

    // Duty holds between loads, so an empty FIFO repeats the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= DUTY_RST;
        end else if (load) begin
            duty <= duty_nxt;
        end
    end

    // Registered compare; cnt < duty means the maximum duty still leaves one low clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= enable && (cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// Stereo PWM audio output stage. Holds the 2-entry sample-pair FIFO, the
// free-running PWM counter, period-boundary detection and the sticky underrun
// flag; the per-channel conversion lives in pwm_audio_chan.
// Build option PWM_AUDIO_NOISE_SHAPE_EN enables per-channel noise shaping.
module pwm_audio_out
    import pwm_audio_out_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int PWM_W    = PWM_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                clr_underrun,
    output logic                underrun,
    output logic                pwm_l,
    output logic                pwm_r
);

    logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [PWM_W-1:0]    cnt;
    logic                push;
    logic                pop;
    logic                boundary;
    fifo_op_e            op;

    // Ready is forced low while reset is held so nothing is accepted into a FIFO being cleared.
    assign s_ready  = rst_n && (count < 2'(FIFO_DEPTH));
    assign push     = s_valid && s_ready;
    assign boundary = enable && (cnt == '1);
    assign pop      = boundary && (count != 2'd0);

    // Classify this cycle's FIFO activity for the occupancy update.
    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = OP_BOTH;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // FIFO occupancy and pointers; reset discards whatever was queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case (op)
                OP_PUSH: count <= count + 2'd1;
                OP_POP:  count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Sample storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= s_left;
            mem_r[wr_ptr] <= s_right;
        end
    end

    // PWM period counter, parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky underrun; a new underrun takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (boundary && (count == 2'd0)) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

    pwm_audio_chan #(
        .SAMPLE_W (SAMPLE_W),
        .PWM_W    (PWM_W)
    ) u_chan_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .load   (pop),
        .sample (mem_l[rd_ptr]),
        .cnt    (cnt),
        .pwm    (pwm_l)
    );

    pwm_audio_chan #(
        .SAMPLE_W (SAMPLE_W),
        .PWM_W    (PWM_W)
    ) u_chan_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .load   (pop),
        .sample (mem_r[rd_ptr]),
        .cnt    (cnt),
        .pwm    (pwm_r)
    );

endmodule
